// File: rtl/zigzag_bram_writer_if.sv
// Stream, BRAM port A and block handshake bundle for zigzag_bram_writer.
// total_coeff exists only when NZ_COUNT_EN is defined.
interface zigzag_bram_writer_if #(
    parameter int addrWIDTH = 4,
    parameter int WIDTH     = 9
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 ena;
    logic                 wea;
    logic [addrWIDTH-1:0] addra;
    logic [WIDTH-1:0]     dia;
    logic                 blk_valid;
    logic                 blk_ack;
    logic                 err;
`ifdef NZ_COUNT_EN
    logic [4:0]           total_coeff;
`endif

    modport master (
        output in_valid, in_data, in_last, blk_ack,
        input  in_ready, ena, wea, addra, dia, blk_valid, err
`ifdef NZ_COUNT_EN
        , input total_coeff
`endif
    );

    modport slave (
        input  in_valid, in_data, in_last, blk_ack,
        output in_ready, ena, wea, addra, dia, blk_valid, err
`ifdef NZ_COUNT_EN
        , output total_coeff
`endif
    );
endinterface

// File: rtl/zigzag_bram_writer.sv
// Inverse-zigzag writer: zigzag-ordered coefficients -> raster BRAM port A.
// Optional NZ_COUNT_EN adds a nonzero-coefficient counter (total_coeff).
module zigzag_bram_writer #(
    parameter int addrWIDTH = 4,
    parameter int WIDTH     = 9,
    parameter int DEPTH     = 16
) (
    input  logic               clk,
    input  logic               rst,
    zigzag_bram_writer_if.slave bus
);
    typedef enum logic [1:0] {ACCEPT, FILL, WAIT1, HOLD} state_t;

    localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic                 ena_q, ena_d;
    logic                 wea_q, wea_d;
    logic [addrWIDTH-1:0] addra_q, addra_d;
    logic [WIDTH-1:0]     dia_q, dia_d;
    logic                 blk_valid_q, blk_valid_d;
    logic                 err_q, err_d;
`ifdef NZ_COUNT_EN
    logic [4:0]           nz_q, nz_d;
`endif

    function automatic logic [3:0] zz(input logic [3:0] i);
        logic [3:0] r;
        case (i)
            4'd0:    r = 4'd0;
            4'd1:    r = 4'd1;
            4'd2:    r = 4'd4;
            4'd3:    r = 4'd8;
            4'd4:    r = 4'd5;
            4'd5:    r = 4'd2;
            4'd6:    r = 4'd3;
            4'd7:    r = 4'd6;
            4'd8:    r = 4'd9;
            4'd9:    r = 4'd12;
            4'd10:   r = 4'd13;
            4'd11:   r = 4'd10;
            4'd12:   r = 4'd7;
            4'd13:   r = 4'd11;
            4'd14:   r = 4'd14;
            default: r = 4'd15;
        endcase
        return r;
    endfunction

    assign bus.in_ready  = (state_q == ACCEPT);
    assign bus.ena       = ena_q;
    assign bus.wea       = wea_q;
    assign bus.addra     = addra_q;
    assign bus.dia       = dia_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.err       = err_q;
`ifdef NZ_COUNT_EN
    assign bus.total_coeff = nz_q;
`endif

    // Next state, write port and block handshake outputs
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ena_d       = 1'b0;
        wea_d       = 1'b0;
        addra_d     = addra_q;
        dia_d       = dia_q;
        blk_valid_d = 1'b0;
        err_d       = 1'b0;
`ifdef NZ_COUNT_EN
        nz_d        = nz_q;
`endif
        unique case (state_q)
            ACCEPT: begin
                if (bus.in_valid) begin
                    ena_d   = 1'b1;
                    wea_d   = 1'b1;
                    addra_d = addrWIDTH'(zz(idx_q));
                    dia_d   = bus.in_data;
`ifdef NZ_COUNT_EN
                    if (bus.in_data != '0) nz_d = nz_q + 5'd1;
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = WAIT1;
                        err_d   = ~bus.in_last;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (bus.in_last) state_d = FILL;
                    end
                end
            end
            FILL: begin
                ena_d   = 1'b1;
                wea_d   = 1'b1;
                addra_d = addrWIDTH'(zz(idx_q));
                dia_d   = '0;
                if (idx_q == LAST_IDX) state_d = WAIT1;
                else idx_d = idx_q + 4'd1;
            end
            WAIT1: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.blk_ack) begin
                    state_d = ACCEPT;
                    idx_d   = 4'd0;
`ifdef NZ_COUNT_EN
                    nz_d    = 5'd0;
`endif
                end else begin
                    blk_valid_d = 1'b1;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ACCEPT;
            idx_q       <= 4'd0;
            ena_q       <= 1'b0;
            wea_q       <= 1'b0;
            addra_q     <= '0;
            dia_q       <= '0;
            blk_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef NZ_COUNT_EN
            nz_q        <= 5'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ena_q       <= ena_d;
            wea_q       <= wea_d;
            addra_q     <= addra_d;
            dia_q       <= dia_d;
            blk_valid_q <= blk_valid_d;
            err_q       <= err_d;
`ifdef NZ_COUNT_EN
            nz_q        <= nz_d;
`endif
        end
    end
endmodule

// File: tb/tb_zigzag_bram_writer.sv
// Directed bench for zigzag_bram_writer: write order, zero fill,
// hold/ack handshake, err pulse, async reset and random-gap blocks.
module tb_zigzag_bram_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [3:0]  zz_t [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
    logic [12:0] wlog [$];
    logic [8:0]  mem  [16];
    logic [8:0]  blk  [16];
    logic [8:0]  img  [16];

    zigzag_bram_writer_if #(.addrWIDTH(4), .WIDTH(9)) bus ();

    zigzag_bram_writer #(.addrWIDTH(4), .WIDTH(9), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // BRAM model and write log
    always @(negedge clk) begin
        if (rst_n && bus.ena && bus.wea) begin
            mem[bus.addra] = bus.dia;
            wlog.push_back({bus.addra, bus.dia});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] d, input logic l);
        bit hs;
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        do begin
            hs = bus.in_ready;
            tick();
            n++;
        end while (!hs && n < 50);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!hs) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_blk();
        int n;
        n = 0;
        while (!bus.blk_valid && n < 100) begin
            tick();
            n++;
        end
        chk("blk_valid_up", 32'(bus.blk_valid), 32'd1);
    endtask

    task automatic ack();
        bus.blk_ack = 1'b1;
        tick();
        bus.blk_ack = 1'b0;
        chk("ack_blk_valid", 32'(bus.blk_valid), 32'd0);
        chk("ack_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef NZ_COUNT_EN
        chk("ack_nz", 32'(bus.total_coeff), 32'd0);
`endif
    endtask

    task automatic check_log(input logic [8:0] d [16]);
        chk("log_size", 32'(wlog.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < wlog.size())
                chk($sformatf("wr%0d", i), 32'(wlog[i]), 32'({zz_t[i], d[i]}));
        end
    endtask

    initial begin
        int n;
        int k;
        int nzc;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.blk_ack  = 1'b0;

        // reset state
        #3;
        chk("rst_ena", 32'(bus.ena), 32'd0);
        chk("rst_wea", 32'(bus.wea), 32'd0);
        chk("rst_addra", 32'(bus.addra), 32'd0);
        chk("rst_dia", 32'(bus.dia), 32'd0);
        chk("rst_blk_valid", 32'(bus.blk_valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // full block 1..16 with latency check
        wlog.delete();
        for (int i = 0; i < 16; i++) begin
            blk[i] = 9'(i + 1);
            send(blk[i], i == 15);
        end
        chk("t1_ena", 32'(bus.ena), 32'd1);
        chk("t1_addra", 32'(bus.addra), 32'd15);
        chk("t1_dia", 32'(bus.dia), 32'd16);
        chk("t1_err", 32'(bus.err), 32'd0);
        chk("t1_bv_t1", 32'(bus.blk_valid), 32'd0);
        tick();
        chk("t1_ena_wait", 32'(bus.ena), 32'd0);
        chk("t1_bv_t2", 32'(bus.blk_valid), 32'd0);
        tick();
        chk("t1_bv_t3", 32'(bus.blk_valid), 32'd1);
        check_log(blk);
`ifdef NZ_COUNT_EN
        chk("t1_nz", 32'(bus.total_coeff), 32'd16);
`endif

        // in_valid held during HOLD is not consumed
        bus.in_valid = 1'b1;
        bus.in_data  = 9'h055;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
        end
        chk("t3_no_writes", 32'(wlog.size()), 32'd16);
        chk("t3_bv_hold", 32'(bus.blk_valid), 32'd1);
        bus.in_valid = 1'b0;
        ack();

        // short block with zero fill
        wlog.delete();
        blk = '{default: 9'h000};
        blk[0] = 9'd5;
        blk[1] = 9'h1FE;
        blk[2] = 9'd7;
        send(blk[0], 1'b0);
        send(blk[1], 1'b0);
        send(blk[2], 1'b1);
        for (int i = 0; i < 13; i++) begin
            chk("t2_fill_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        wait_blk();
        check_log(blk);
`ifdef NZ_COUNT_EN
        chk("t2_nz", 32'(bus.total_coeff), 32'd3);
`endif
        ack();

        // 16th coefficient without in_last
        wlog.delete();
        for (int i = 0; i < 16; i++) begin
            blk[i] = 9'(i + 1);
            send(blk[i], 1'b0);
        end
        chk("t4_err_pulse", 32'(bus.err), 32'd1);
        tick();
        chk("t4_err_clear", 32'(bus.err), 32'd0);
        wait_blk();
        check_log(blk);
        ack();

        // asynchronous reset mid-block
        for (int i = 0; i < 6; i++) send(9'(i + 40), 1'b0);
        chk("t5_ena_pre", 32'(bus.ena), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_ena", 32'(bus.ena), 32'd0);
        chk("t5_wea", 32'(bus.wea), 32'd0);
        chk("t5_addra", 32'(bus.addra), 32'd0);
        chk("t5_dia", 32'(bus.dia), 32'd0);
        chk("t5_bv", 32'(bus.blk_valid), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        wlog.delete();
        for (int i = 0; i < 16; i++) begin
            blk[i] = 9'(i + 101);
            send(blk[i], i == 15);
        end
        wait_blk();
        check_log(blk);
        ack();

        // random gaps, lengths and data
        for (int b = 0; b < 20; b++) begin
            n = int'($urandom_range(1, 16));
            nzc = 0;
            for (int i = 0; i < 16; i++) begin
                if (i < n) blk[i] = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom);
                else blk[i] = 9'h000;
                if (blk[i] != 9'h000) nzc++;
                img[zz_t[i]] = blk[i];
            end
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    k = int'($urandom_range(1, 3));
                    repeat (k) tick();
                end
                send(blk[i], i == n - 1);
            end
            wait_blk();
            for (int a = 0; a < 16; a++)
                chk($sformatf("rnd%0d_mem%0d", b, a), 32'(mem[a]), 32'(img[a]));
`ifdef NZ_COUNT_EN
            chk("rnd_nz", 32'(bus.total_coeff), 32'(nzc));
`endif
            k = int'($urandom_range(0, 3));
            repeat (k) tick();
            ack();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
